jacobi_sweep_ctrl: RTL and testbench
====================================

Name: jacobi_sweep_ctrl

Overview:
- Sequences cyclic-Jacobi sweeps over an N×N symmetric matrix held in the matrix register file.
- For each upper-triangle pivot pair (i,j), reads M_ij. If |M_ij| >= tol, it dispatches a rotation to the rotation datapath and waits for completion.
- Terminates on a sweep with zero rotations (converged) or when MAX_SWEEPS is reached (timeout).
- Sits between the top-level start/status interface and the matrix-store/rotation datapath.

Parameters:
- N, 4, matrix dimension (N >= 2).
- IW, 3, index width; must satisfy 2^IW >= N.
- DW, 32, data width of M_ij and tol.
- MAX_SWEEPS, 16, sweep limit (>= 1).
- SW, 5, sweep counter width; must satisfy 2^SW > MAX_SWEEPS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE only.
- tol  in  DW  unsigned convergence threshold; latched at start.
- rd_en  out  1  matrix read strobe.
- rd_i  out  IW  read row index.
- rd_j  out  IW  read column index.
- M_ij  in  DW  signed two's-complement element, valid exactly 1 cycle after rd_en.
- rot_req  out  1  rotation request (valid).
- rot_ready  in  1  datapath accepts the request.
- rot_i  out  IW  rotation pivot row.
- rot_j  out  IW  rotation pivot column.
- rot_done  in  1  single-cycle pulse: rotation complete.
- busy  out  1  run in progress.
- done  out  1  single-cycle end-of-run pulse.
- converged  out  1  last run converged.
- timeout  out  1  last run hit MAX_SWEEPS.
- sweep_count  out  SW  completed sweeps in current/last run.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; internal i=0, j=1, rot_flag=0, tol_q=0.
- States: IDLE, READ, EVAL, ROT_REQ, ROT_WAIT, NEXT, DONE.
- IDLE:
  - On start=1: tol_q<=tol; i<=0; j<=1; sweep_count<=0; converged<=0; timeout<=0; rot_flag<=0; busy<=1; go to READ.
  - start is ignored in every other state.
- READ (1 cycle): rd_en=1, rd_i=i, rd_j=j; go to EVAL.
- EVAL (1 cycle):
  - mag = |M_ij|; M_ij = 0x80000000 saturates to 0x7FFFFFFF.
  - If mag >= tol_q (unsigned compare): rot_flag<=1, go to ROT_REQ. Otherwise go to NEXT.
  - tol_q=0 forces a rotation on every pair.
- ROT_REQ:
  - rot_req=1, rot_i=i, rot_j=j, held stable until the cycle in which rot_ready=1.
  - Transfer occurs on rot_req&rot_ready; rot_req drops the next cycle; go to ROT_WAIT.
- ROT_WAIT: wait for rot_done, then go to NEXT. rot_done in any other state is ignored.
- NEXT (1 cycle), row-cyclic order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1):
  - If j<N-1: j<=j+1.
  - Else if i<N-2: i<=i+1, j<=i+2.
  - Else end of sweep: sweep_count<=sweep_count+1, then:
    - If rot_flag=0: converged<=1, go to DONE.
    - Else if sweep_count+1 == MAX_SWEEPS: timeout<=1, go to DONE.
    - Else: i<=0, j<=1, rot_flag<=0.
  - Otherwise go to READ.
  - Converged takes priority over timeout on the final sweep.
- DONE (1 cycle): done=1, busy<=0; go to IDLE. converged, timeout and sweep_count hold until the next start.
- Timing:
  - Non-rotated pair: exactly 3 cycles (READ, EVAL, NEXT).
  - Rotated pair: 3 + ready wait + 1 + done wait.
  - Pairs per sweep: N(N-1)/2.
- Reset mid-operation: immediate return to IDLE; any outstanding rotation is abandoned, and rot_req deasserts asynchronously.
- rd_i/rd_j and rot_i/rot_j are don't-care while their strobes are low; they are held at their last value.

Test Plan:
- N=4, tol=0x100, all |M_ij|<0x100 → 6 reads, no rot_req; done 18 cycles after leaving IDLE; converged=1, timeout=0, sweep_count=1.
- N=4, tol=0x100, M_02=0x200 in sweep 1 only, rot_ready tied 1, rot_done 2 cycles after accept → exactly one rotation with rot_i=0, rot_j=2; converged=1, sweep_count=2.
- All M_ij=0x7FFFFFFF, MAX_SWEEPS=3 → 18 rotations; pair order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) repeated; timeout=1, converged=0, sweep_count=3.
- rot_ready held low 5 cycles → rot_req, rot_i and rot_j stay stable all 5 cycles; single transfer; rot_req low the cycle after acceptance.
- M_ij=0x80000000, tol=0x7FFFFFFF → rotation issued (saturated mag equals tol). With tol=0xFFFFFFFF the same element produces no rotation.
- reset pulsed low during ROT_WAIT → all outputs 0 immediately; a later start restarts at (0,1) with sweep_count=0. start pulsed while busy → no effect.

Source files
------------

// File: rtl/jacobi_sweep_ctrl.sv
// jacobi_sweep_ctrl: sequences cyclic-Jacobi sweeps over the upper triangle of
// an N x N symmetric matrix. Each off-diagonal element is read once per sweep
// and, if its magnitude reaches the latched tolerance, a rotation is handed to
// the rotation datapath. A run ends on the first sweep that needs no rotation
// (converged) or after MAX_SWEEPS sweeps (timeout).
module jacobi_sweep_ctrl #(
    parameter int N          = 4,
    parameter int IW         = 3,
    parameter int DW         = 32,
    parameter int MAX_SWEEPS = 16,
    parameter int SW         = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] tol,
    output logic          rd_en,
    output logic [IW-1:0] rd_i,
    output logic [IW-1:0] rd_j,
    input  logic [DW-1:0] M_ij,
    output logic          rot_req,
    input  logic          rot_ready,
    output logic [IW-1:0] rot_i,
    output logic [IW-1:0] rot_j,
    input  logic          rot_done,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic          timeout,
    output logic [SW-1:0] sweep_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_ROT_REQ,
        S_ROT_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

    state_t        state_q;
    logic [IW-1:0] i_q, j_q;
    logic          rotFlag_q;
    logic [DW-1:0] tol_q;
    logic          rdEn_q, rotReq_q, busy_q, done_q, converged_q, timeout_q;
    logic [IW-1:0] rdI_q, rdJ_q, rotI_q, rotJ_q;
    logic [SW-1:0] sweepCount_q;

    logic [DW-1:0] mag;
    logic          magGeTol;
    logic          endOfSweep;
    logic [IW-1:0] iNext_d, jNext_d;
    logic [SW-1:0] sweepNext_d;

    assign rd_en       = rdEn_q;
    assign rd_i        = rdI_q;
    assign rd_j        = rdJ_q;
    assign rot_req     = rotReq_q;
    assign rot_i       = rotI_q;
    assign rot_j       = rotJ_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = converged_q;
    assign timeout     = timeout_q;
    assign sweep_count = sweepCount_q;

    // Absolute value of the element just read; the most negative value has no
    // positive twin, so it saturates to the largest positive value.
    always_comb begin
        mag = M_ij;
        if (M_ij == MOST_NEG) begin
            mag = MOST_POS;
        end else if (M_ij[DW-1]) begin
            mag = ~M_ij + DW'(1);
        end
        magGeTol = (mag >= tol_q);
    end

    // Next pivot pair in row-cyclic order, wrapping to (0,1) at end of sweep.
    always_comb begin
        endOfSweep  = (j_q == IW'(N-1)) && (i_q == IW'(N-2));
        sweepNext_d = sweepCount_q + SW'(1);
        iNext_d     = i_q;
        jNext_d     = j_q + IW'(1);
        if (j_q == IW'(N-1)) begin
            if (i_q == IW'(N-2)) begin
                iNext_d = '0;
                jNext_d = IW'(1);
            end else begin
                iNext_d = i_q + IW'(1);
                jNext_d = i_q + IW'(2);
            end
        end
    end

    // Sweep sequencer; every output is a register loaded on the transition
    // into the state that owns it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            j_q          <= IW'(1);
            rotFlag_q    <= 1'b0;
            tol_q        <= '0;
            rdEn_q       <= 1'b0;
            rdI_q        <= '0;
            rdJ_q        <= '0;
            rotReq_q     <= 1'b0;
            rotI_q       <= '0;
            rotJ_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            converged_q  <= 1'b0;
            timeout_q    <= 1'b0;
            sweepCount_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tol_q        <= tol;
                        i_q          <= '0;
                        j_q          <= IW'(1);
                        sweepCount_q <= '0;
                        converged_q  <= 1'b0;
                        timeout_q    <= 1'b0;
                        rotFlag_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        rdEn_q       <= 1'b1;
                        rdI_q        <= '0;
                        rdJ_q        <= IW'(1);
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    rdEn_q  <= 1'b0;
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    if (magGeTol) begin
                        rotFlag_q <= 1'b1;
                        rotReq_q  <= 1'b1;
                        rotI_q    <= i_q;
                        rotJ_q    <= j_q;
                        state_q   <= S_ROT_REQ;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_ROT_REQ: begin
                    if (rot_ready) begin
                        rotReq_q <= 1'b0;
                        state_q  <= S_ROT_WAIT;
                    end
                end
                S_ROT_WAIT: begin
                    if (rot_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (endOfSweep && !rotFlag_q) begin
                        sweepCount_q <= sweepNext_d;
                        converged_q  <= 1'b1;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (endOfSweep && (sweepNext_d == SW'(MAX_SWEEPS))) begin
                        sweepCount_q <= sweepNext_d;
                        timeout_q    <= 1'b1;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        if (endOfSweep) begin
                            sweepCount_q <= sweepNext_d;
                            rotFlag_q    <= 1'b0;
                        end
                        i_q     <= iNext_d;
                        j_q     <= jNext_d;
                        rdEn_q  <= 1'b1;
                        rdI_q   <= iNext_d;
                        rdJ_q   <= jNext_d;
                        state_q <= S_READ;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
// tb_jacobi_sweep_ctrl: directed bench for jacobi_sweep_ctrl with a behavioural
// matrix store and rotation datapath; expected values are hand-derived.
module tb_jacobi_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] tol = '0;
    logic        rd_en;
    logic [2:0]  rd_i, rd_j;
    logic [31:0] M_ij;
    logic        rot_req;
    logic        rot_ready;
    logic [2:0]  rot_i, rot_j;
    logic        rot_done;
    logic        busy, done, converged, timeout;
    logic [4:0]  sweep_count;

    int checks = 0;
    int errors = 0;

    // Matrix contents and datapath behaviour, set up by the main sequence.
    logic [31:0] mem [0:7][0:7];
    int          rotEpoch [0:7][0:7];
    int          runId = 0;
    bit          zeroOnRot = 1'b0;
    int          readyDelay = 0;
    int          doneDelay = 2;

    // Observations collected by the model.
    int          readCount = 0;
    int          rotCount = 0;
    int          reqHigh = 0;
    int          rdLogI [0:1023];
    int          rdLogJ [0:1023];
    int          rotLogI [0:255];
    int          rotLogJ [0:255];

    int          pairI [6] = '{0, 0, 0, 1, 1, 2};
    int          pairJ [6] = '{1, 2, 3, 2, 3, 3};

    int          readBase, rotBase, reqBase, cycles;

    jacobi_sweep_ctrl #(
        .N(4), .IW(3), .DW(32), .MAX_SWEEPS(3), .SW(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .tol(tol),
        .rd_en(rd_en),
        .rd_i(rd_i),
        .rd_j(rd_j),
        .M_ij(M_ij),
        .rot_req(rot_req),
        .rot_ready(rot_ready),
        .rot_i(rot_i),
        .rot_j(rot_j),
        .rot_done(rot_done),
        .busy(busy),
        .done(done),
        .converged(converged),
        .timeout(timeout),
        .sweep_count(sweep_count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadMem(input logic [31:0] value);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem[r][c] = value;
    endtask

    // Begin a run: snapshot model counters, then pulse start for one cycle.
    task automatic applyStimulus(input logic [31:0] tolValue);
        @(negedge clk);
        #1;
        runId++;
        readBase = readCount;
        rotBase  = rotCount;
        reqBase  = reqHigh;
        tol      = tolValue;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start    = 1'b0;
        checkOutput("busyAfterStart", {31'b0, busy}, 1);
    endtask

    task automatic waitDone(input int limit, output int count);
        count = 0;
        while (count < limit) begin
            @(negedge clk);
            #1;
            count++;
            if (done) break;
        end
        checkOutput("doneSeen", {31'b0, done}, 1);
    endtask

    task automatic checkResult(input string tag, input logic conv, input logic tmo,
                               input int sweeps, input int rots);
        checkOutput({tag, ".converged"}, {31'b0, converged}, {31'b0, conv});
        checkOutput({tag, ".timeout"}, {31'b0, timeout}, {31'b0, tmo});
        checkOutput({tag, ".sweeps"}, {27'b0, sweep_count}, sweeps);
        checkOutput({tag, ".rotations"}, rotCount - rotBase, rots);
        @(negedge clk);
        #1;
        checkOutput({tag, ".doneDrop"}, {31'b0, done}, 0);
        checkOutput({tag, ".busyDrop"}, {31'b0, busy}, 0);
        checkOutput({tag, ".convHold"}, {31'b0, converged}, {31'b0, conv});
        checkOutput({tag, ".sweepHold"}, {27'b0, sweep_count}, sweeps);
    endtask

    // Behavioural matrix store and rotation datapath, evaluated mid-cycle.
    initial begin : model
        int phase;
        int lowCnt;
        int cnt;
        int holdI, holdJ;
        phase = 0; lowCnt = 0; cnt = 0; holdI = 0; holdJ = 0;
        rot_ready = 1'b0;
        rot_done  = 1'b0;
        M_ij      = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                rotEpoch[r][c] = -1;
        forever begin
            @(negedge clk);
            if (rd_en) begin
                M_ij = (zeroOnRot && rotEpoch[rd_i][rd_j] == runId) ? 32'h0 : mem[rd_i][rd_j];
                if (readCount < 1024) begin
                    rdLogI[readCount] = int'(rd_i);
                    rdLogJ[readCount] = int'(rd_j);
                end
                readCount++;
            end
            if (rot_req) reqHigh++;
            if (!reset) begin
                phase = 0; lowCnt = 0; cnt = 0;
                rot_ready = 1'b0;
                rot_done  = 1'b0;
            end else begin
                if (rot_done) rot_done = 1'b0;
                case (phase)
                    0: if (rot_req) begin
                        if (lowCnt == 0) begin
                            holdI = int'(rot_i);
                            holdJ = int'(rot_j);
                        end else begin
                            checkOutput("reqStableI", {29'b0, rot_i}, holdI);
                            checkOutput("reqStableJ", {29'b0, rot_j}, holdJ);
                        end
                        if (lowCnt == readyDelay) begin
                            rot_ready = 1'b1;
                            phase = 1;
                        end else begin
                            lowCnt++;
                        end
                    end
                    1: begin
                        checkOutput("reqDropAfterAccept", {31'b0, rot_req}, 0);
                        if (rotCount < 256) begin
                            rotLogI[rotCount] = holdI;
                            rotLogJ[rotCount] = holdJ;
                        end
                        rotCount++;
                        rot_ready = 1'b0;
                        lowCnt = 0;
                        cnt = doneDelay - 1;
                        phase = 2;
                        if (cnt <= 0) begin
                            rot_done = 1'b1;
                            rotEpoch[holdI][holdJ] = runId;
                            phase = 0;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt <= 0) begin
                            rot_done = 1'b1;
                            rotEpoch[holdI][holdJ] = runId;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Main directed sequence.
    initial begin : mainSeq
        int waitCnt;
        loadMem(32'h0);

        // Reset state.
        #12;
        checkOutput("rstRdEn", {31'b0, rd_en}, 0);
        checkOutput("rstRotReq", {31'b0, rot_req}, 0);
        checkOutput("rstBusy", {31'b0, busy}, 0);
        checkOutput("rstDone", {31'b0, done}, 0);
        checkOutput("rstConv", {31'b0, converged}, 0);
        checkOutput("rstTimeout", {31'b0, timeout}, 0);
        checkOutput("rstSweeps", {27'b0, sweep_count}, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;

        // Quiet matrix: six reads, no rotations, done 18 cycles after IDLE.
        $display("[TB] test 1: no rotations needed");
        loadMem(32'h0000_0010);
        mem[0][3] = 32'hFFFF_FF01;
        mem[1][2] = 32'h0000_00FF;
        zeroOnRot = 1'b0;
        applyStimulus(32'h100);
        waitDone(200, cycles);
        checkOutput("t1.doneCycles", cycles, 18);
        checkOutput("t1.reads", readCount - readBase, 6);
        checkOutput("t1.reqHigh", reqHigh - reqBase, 0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("t1.readI", rdLogI[readBase + k], pairI[k]);
            checkOutput("t1.readJ", rdLogJ[readBase + k], pairJ[k]);
        end
        checkResult("t1", 1'b1, 1'b0, 1, 0);

        // One large element in the first sweep only.
        $display("[TB] test 2: single rotation at (0,2)");
        loadMem(32'h0000_0010);
        mem[0][2] = 32'h0000_0200;
        zeroOnRot = 1'b1;
        readyDelay = 0;
        doneDelay = 2;
        applyStimulus(32'h100);
        waitDone(500, cycles);
        checkOutput("t2.rotI", rotLogI[rotBase], 0);
        checkOutput("t2.rotJ", rotLogJ[rotBase], 2);
        checkOutput("t2.reqHigh", reqHigh - reqBase, 1);
        checkOutput("t2.reads", readCount - readBase, 12);
        checkResult("t2", 1'b1, 1'b0, 2, 1);

        // Saturated matrix never converges; start while busy is ignored.
        $display("[TB] test 3: timeout after MAX_SWEEPS");
        loadMem(32'h7FFF_FFFF);
        zeroOnRot = 1'b0;
        applyStimulus(32'h100);
        repeat (20) @(negedge clk);
        #1;
        start = 1'b1;
        tol   = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        start = 1'b0;
        checkOutput("t3.busyMidRun", {31'b0, busy}, 1);
        waitDone(2000, cycles);
        for (int k = 0; k < 18; k++) begin
            checkOutput("t3.rotI", rotLogI[rotBase + k], pairI[k % 6]);
            checkOutput("t3.rotJ", rotLogJ[rotBase + k], pairJ[k % 6]);
        end
        checkResult("t3", 1'b0, 1'b1, 3, 18);

        // Slow datapath acceptance: request held for five cycles.
        $display("[TB] test 4: rot_ready low for 5 cycles");
        loadMem(32'h0000_0020);
        mem[1][3] = 32'h0000_0300;
        zeroOnRot = 1'b1;
        readyDelay = 5;
        applyStimulus(32'h100);
        waitDone(500, cycles);
        checkOutput("t4.reqHigh", reqHigh - reqBase, 6);
        checkOutput("t4.rotI", rotLogI[rotBase], 1);
        checkOutput("t4.rotJ", rotLogJ[rotBase], 3);
        checkResult("t4", 1'b1, 1'b0, 2, 1);
        readyDelay = 0;

        // Most negative element saturates to 0x7FFFFFFF.
        $display("[TB] test 5: saturated magnitude boundary");
        loadMem(32'h0);
        mem[0][1] = 32'h8000_0000;
        applyStimulus(32'h7FFF_FFFF);
        waitDone(500, cycles);
        checkOutput("t5a.rotI", rotLogI[rotBase], 0);
        checkOutput("t5a.rotJ", rotLogJ[rotBase], 1);
        checkResult("t5a", 1'b1, 1'b0, 2, 1);
        applyStimulus(32'h8000_0000);
        waitDone(500, cycles);
        checkResult("t5b", 1'b1, 1'b0, 1, 0);
        applyStimulus(32'hFFFF_FFFF);
        waitDone(500, cycles);
        checkResult("t5c", 1'b1, 1'b0, 1, 0);

        // Reset while a rotation is outstanding, then a clean restart.
        $display("[TB] test 6: reset during ROT_WAIT");
        loadMem(32'h0);
        mem[0][1] = 32'h0000_0200;
        doneDelay = 1000;
        applyStimulus(32'h100);
        waitCnt = 0;
        while (rotCount == rotBase && waitCnt < 100) begin
            @(negedge clk);
            #2;
            waitCnt++;
        end
        checkOutput("t6.accepted", rotCount - rotBase, 1);
        reset = 1'b0;
        #1;
        checkOutput("t6.rstRotReq", {31'b0, rot_req}, 0);
        checkOutput("t6.rstRotJ", {29'b0, rot_j}, 0);
        checkOutput("t6.rstRdJ", {29'b0, rd_j}, 0);
        checkOutput("t6.rstBusy", {31'b0, busy}, 0);
        checkOutput("t6.rstDone", {31'b0, done}, 0);
        checkOutput("t6.rstConv", {31'b0, converged}, 0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        doneDelay = 2;
        mem[0][1] = 32'h0;
        applyStimulus(32'h100);
        checkOutput("t6.sweepsAtRestart", {27'b0, sweep_count}, 0);
        waitDone(500, cycles);
        checkOutput("t6.firstReadI", rdLogI[readBase], 0);
        checkOutput("t6.firstReadJ", rdLogJ[readBase], 1);
        checkResult("t6", 1'b1, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
